puf_challenge_sequencer: RTL
============================

PUF_CHALLENGE_SEQUENCER -- requirements
Module: puf_challenge_sequencer

Interface
REQ-001 Parameter N_VOTES, default 3: evaluations per challenge; odd, 1..15.
REQ-002 Parameter SETTLE, default 4: idle cycles after each pulse before sampling; 3..255.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous reset, active-high.
REQ-005 start  input  1  one-cycle request to begin a run; honoured only in IDLE.
REQ-006 seed  input  8  challenge LFSR seed, captured on accepted start.
REQ-007 ochallenge  output  8  challenge vector driven to the PUF delay line.
REQ-008 opulse  output  1  race pulse to the PUF; high for exactly one cycle per evaluation.
REQ-009 iresponse  input  1  PUF arbiter response; asynchronous to clk.
REQ-010 busy  output  1  high from the cycle after accepted start through DONE.
REQ-011 done  output  1  one-cycle strobe: oresult/ounstable updated.
REQ-012 oresult  output  8  majority-voted response byte, first challenge in bit 7.
REQ-013 ounstable  output  8  per-bit flag: votes for that bit were not unanimous.

Function
REQ-014 iresponse SHALL pass through a 2-flop synchronizer; only the synchronized value is sampled.
REQ-015 States SHALL be IDLE, SETUP, FIRE, WAIT, SAMPLE, DECIDE, DONE.
REQ-016 IDLE: on start=1, load LFSR with seed (8'h00 replaced by 8'h01), clear bit index, vote counters and shift registers -> SETUP.
REQ-017 SETUP (1 cycle): ochallenge = LFSR value, held constant until the next SETUP; -> FIRE.
REQ-018 FIRE (1 cycle): opulse=1; -> WAIT.
REQ-019 WAIT (exactly SETTLE cycles): opulse=0; -> SAMPLE.
REQ-020 SAMPLE (1 cycle): add synchronized response to ones-counter, increment vote counter; if votes < N_VOTES -> FIRE, else -> DECIDE.
REQ-021 DECIDE (1 cycle): bit = (ones > N_VOTES/2); shift bit into result shift register LSB side (left shift); unstable bit = (ones != 0 && ones != N_VOTES); clear counters; advance LFSR; if bit index = 7 -> DONE else increment index -> SETUP.
REQ-022 LFSR: Fibonacci left shift, new LSB = c[7]^c[5]^c[4]^c[3] (x^8+x^6+x^5+x^4+1); period 255.
REQ-023 DONE (1 cycle): copy shift registers to oresult/ounstable, done=1, busy=0 next cycle; -> IDLE.
REQ-024 Per-bit latency SHALL be 2 + N_VOTES*(SETTLE+2) cycles; default 20; full run 160 cycles from SETUP entry to DONE.
REQ-025 start while not IDLE SHALL be ignored (no restart, no queueing); start in the DONE cycle ignored.
REQ-026 oresult/ounstable SHALL change only in DONE and hold until the next DONE or reset.
REQ-027 opulse SHALL never be high in two consecutive cycles; ochallenge SHALL never change while opulse=1 or during WAIT.

Reset
REQ-028 rst=1 SHALL force IDLE and ochallenge=8'h00, opulse=0, busy=0, done=0, oresult=8'h00, ounstable=8'h00, LFSR=8'h01, counters and synchronizer cleared.
REQ-029 rst asserted mid-run SHALL abort without done; outputs take reset values the next cycle; start the cycle after rst deasserts is accepted.
REQ-030 rst has priority over start.

Verification
REQ-031 seed=8'h01, start, iresponse tied 1 -> ochallenge sequence 01,02,04,08,11,23,47,8E; done at cycle 160 after SETUP entry; oresult=8'hFF, ounstable=8'h00.
REQ-032 seed=8'h00, iresponse tied 0 -> first ochallenge 8'h01; oresult=8'h00, ounstable=8'h00.
REQ-033 Model responds 1 only on 2nd of 3 votes for bit 0 (first challenge) -> that bit 0 by majority, oresult[7]=0, ounstable=8'h80.
REQ-034 Count opulse high cycles per run = 24 (8 x 3), each isolated, spacing 6 cycles within a bit; ochallenge stable across each.
REQ-035 rst at cycle 50 of a run -> no done, all outputs reset next cycle; new start with seed=8'hA5 runs to completion with first ochallenge 8'hA5.
REQ-036 start pulsed repeatedly during busy -> exactly one done per accepted start, run timing unchanged.

Source files
------------

// File: rtl/puf_challenge_sequencer.sv
// Drives an arbiter PUF with LFSR-generated challenges, fires N_VOTES race pulses
// per challenge and majority-votes the synchronized responses into one result byte.
module puf_challenge_sequencer #(
    parameter int N_VOTES = 3,
    parameter int SETTLE  = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] seed,
    output logic [7:0] ochallenge,
    output logic       opulse,
    input  logic       iresponse,
    output logic       busy,
    output logic       done,
    output logic [7:0] oresult,
    output logic [7:0] ounstable
);
    localparam int         SYNC_STAGES = 2;
    localparam logic [3:0] VOTES_N     = 4'(N_VOTES);
    localparam logic [3:0] VOTES_HALF  = 4'(N_VOTES / 2);
    localparam logic [7:0] WAIT_LAST   = 8'(SETTLE - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_FIRE, S_WAIT, S_SAMPLE, S_DECIDE, S_DONE
    } state_t;

    state_t state_reg, state_next;

    logic [SYNC_STAGES-1:0] sync_reg, sync_next;
    logic [7:0] lfsr_reg, ochallenge_reg, oresult_reg, ounstable_reg;
    logic [7:0] res_sh_reg, uns_sh_reg, wait_cnt_reg;
    logic [3:0] vote_cnt_reg, ones_cnt_reg;
    logic [2:0] bit_idx_reg;

    logic [7:0] seed_fix, lfsr_adv, res_next, uns_next;
    logic [3:0] votes_inc;
    logic       vote_bit, vote_split, resp_sync;

    // Response synchronizer chain; only the last stage is ever sampled.
    generate
        for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            if (gi == 0) begin : g_first
                assign sync_next[gi] = iresponse;
            end else begin : g_rest
                assign sync_next[gi] = sync_reg[gi-1];
            end
        end
    endgenerate

    assign resp_sync  = sync_reg[SYNC_STAGES-1];
    assign seed_fix   = (seed == 8'h00) ? 8'h01 : seed;
    assign lfsr_adv   = {lfsr_reg[6:0], lfsr_reg[7] ^ lfsr_reg[5] ^ lfsr_reg[4] ^ lfsr_reg[3]};
    assign votes_inc  = vote_cnt_reg + 4'd1;
    assign vote_bit   = (ones_cnt_reg > VOTES_HALF);
    assign vote_split = (ones_cnt_reg != 4'd0) && (ones_cnt_reg != VOTES_N);
    assign res_next   = {res_sh_reg[6:0], vote_bit};
    assign uns_next   = {uns_sh_reg[6:0], vote_split};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:   if (start) state_next = S_SETUP;
            S_SETUP:  state_next = S_FIRE;
            S_FIRE:   state_next = S_WAIT;
            S_WAIT:   if (wait_cnt_reg == WAIT_LAST) state_next = S_SAMPLE;
            S_SAMPLE: state_next = (votes_inc == VOTES_N) ? S_DECIDE : S_FIRE;
            S_DECIDE: state_next = (bit_idx_reg == 3'd7) ? S_DONE : S_SETUP;
            S_DONE:   state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_reg       <= '0;
            lfsr_reg       <= 8'h01;
            ochallenge_reg <= 8'h00;
            oresult_reg    <= 8'h00;
            ounstable_reg  <= 8'h00;
            res_sh_reg     <= 8'h00;
            uns_sh_reg     <= 8'h00;
            wait_cnt_reg   <= 8'h00;
            vote_cnt_reg   <= 4'd0;
            ones_cnt_reg   <= 4'd0;
            bit_idx_reg    <= 3'd0;
        end else begin
            sync_reg <= sync_next;
            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        lfsr_reg       <= seed_fix;
                        ochallenge_reg <= seed_fix;
                        bit_idx_reg    <= 3'd0;
                        vote_cnt_reg   <= 4'd0;
                        ones_cnt_reg   <= 4'd0;
                        res_sh_reg     <= 8'h00;
                        uns_sh_reg     <= 8'h00;
                    end
                end
                S_FIRE:   wait_cnt_reg <= 8'h00;
                S_WAIT:   wait_cnt_reg <= wait_cnt_reg + 8'd1;
                S_SAMPLE: begin
                    ones_cnt_reg <= ones_cnt_reg + {3'b000, resp_sync};
                    vote_cnt_reg <= votes_inc;
                end
                S_DECIDE: begin
                    res_sh_reg   <= res_next;
                    uns_sh_reg   <= uns_next;
                    vote_cnt_reg <= 4'd0;
                    ones_cnt_reg <= 4'd0;
                    lfsr_reg     <= lfsr_adv;
                    // Results become visible together with the done strobe.
                    if (bit_idx_reg == 3'd7) begin
                        oresult_reg   <= res_next;
                        ounstable_reg <= uns_next;
                    end else begin
                        ochallenge_reg <= lfsr_adv;
                        bit_idx_reg    <= bit_idx_reg + 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign ochallenge = ochallenge_reg;
    assign opulse     = (state_reg == S_FIRE);
    assign busy       = (state_reg != S_IDLE);
    assign done       = (state_reg == S_DONE);
    assign oresult    = oresult_reg;
    assign ounstable  = ounstable_reg;

endmodule
